calc_sequencer: RTL

Control FSM for the keypad calculator. Sits between the key decoder, which supplies one-cycle key events already classified as num/op/c/equ, and the arithmetic unit. It accumulates decimal operands A and B from digit keys and latches the operator. On "=" it issues a start/done handshake to the ALU, then routes the result or an error to the display.

---
 rtl/calc_pkg.sv | 22 ++
 rtl/calc_sequencer_if.sv | 37 +++
 rtl/calc_digit_acc.sv | 40 ++++
 rtl/calc_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator sequencer: operator codes,
// FSM state encoding and default sizing.
package calc_pkg;

  localparam int DIGITS_DEF = 3;
  localparam int W_DEF      = 10;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    OP_WAIT = 3'd1,
    ENTER_B = 3'd2,
    CALC    = 3'd3,
    SHOW    = 3'd4,
    ERR     = 3'd5
  } state_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// Bundle between the sequencer (master) and its environment (slave): key
// decoder, ALU and display.
// Handshakes: key_* fields are meaningful only in a cycle with key_valid=1
// (no back-pressure, a key is taken or dropped in that cycle). alu_start is a
// one-cycle request; alu_done is a one-cycle reply, and alu_result/alu_err are
// meaningful only while alu_done=1.
interface calc_sequencer_if #(parameter int W = 10);
  logic         key_valid;
  logic         key_num;
  logic         key_op;
  logic         key_c;
  logic         key_equ;
  logic [3:0]   key_digit;
  logic [1:0]   key_operator;
  logic         alu_start;
  logic [1:0]   alu_op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         alu_done;
  logic [W-1:0] alu_result;
  logic         alu_err;
  logic [W-1:0] disp_value;
  logic         error;
  logic         busy;

  modport master (
    input  key_valid, key_num, key_op, key_c, key_equ, key_digit, key_operator,
    input  alu_done, alu_result, alu_err,
    output alu_start, alu_op, operand_a, operand_b, disp_value, error, busy
  );

  modport slave (
    output key_valid, key_num, key_op, key_c, key_equ, key_digit, key_operator,
    output alu_done, alu_result, alu_err,
    input  alu_start, alu_op, operand_a, operand_b, disp_value, error, busy
  );
endinterface

// File: rtl/calc_digit_acc.sv
// Decimal operand builder: computes the next operand value for a digit key and
// owns the digit counter (saturation and leading-zero handling).
module calc_digit_acc #(
  parameter int DIGITS = 3,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_cnt,
  input  logic         load,
  input  logic         append,
  input  logic [3:0]   digit,
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);
  localparam int CW = $clog2(DIGITS + 1);

  logic [CW-1:0] count;
  logic          room;

  assign room = (count < CW'(DIGITS));

  // With fewer than DIGITS significant digits, cur*10+d stays below 10^DIGITS.
  always_comb begin
    nxt = cur;
    if (load)
      nxt = W'(digit);
    else if (append && room)
      nxt = W'(32'(cur) * 32'd10 + 32'(digit));
  end

  always_ff @(posedge clk) begin
    if (reset || clr_cnt)
      count <= '0;
    else if (load)
      count <= CW'(digit != 4'd0);
    else if (append && room && !(cur == '0 && digit == 4'd0))
      count <= count + CW'(1);
  end
endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: builds operands A/B from digit keys, runs one ALU
// start/done transaction on "=", and routes result or error to the display.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int W      = W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  calc_sequencer_if.master  bus,
  output state_t            state_dbg
);
  state_t       state, state_n;
  logic [W-1:0] a_q, a_n, b_q, b_n, disp_q, disp_n;
  logic [1:0]   op_q, op_n;
  logic         start_q, start_n, err_q, err_n, busy_q;
  logic         key_ok, sel_b, ld, ap, clr;
  logic [W-1:0] acc_cur, acc_nxt;

  assign key_ok = bus.key_valid
               && $onehot({bus.key_num, bus.key_op, bus.key_c, bus.key_equ})
               && !(bus.key_num && bus.key_digit > 4'd9);

  // One accumulator serves both operands; B is being built in OP_WAIT/ENTER_B.
  assign sel_b   = (state == OP_WAIT) || (state == ENTER_B);
  assign acc_cur = sel_b ? b_q : a_q;
  assign ap  = key_ok && bus.key_num && (state == ENTER_A || state == ENTER_B);
  assign ld  = key_ok && bus.key_num && (state == OP_WAIT || state == SHOW);
  assign clr = key_ok && (state != CALC)
            && (bus.key_c || (bus.key_op && (state == ENTER_A || state == SHOW)));

  calc_digit_acc #(.DIGITS(DIGITS), .W(W)) u_acc (
    .clk(clk), .reset(reset), .clr_cnt(clr), .load(ld), .append(ap),
    .digit(bus.key_digit), .cur(acc_cur), .nxt(acc_nxt)
  );

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    start_n = 1'b0;
    disp_n  = disp_q;
    err_n   = err_q;
    if (state == CALC) begin
      // A done coinciding with the start pulse cannot be a reply to it.
      if (bus.alu_done && !start_q) begin
        if (bus.alu_err) begin
          err_n   = 1'b1;
          disp_n  = '0;
          state_n = ERR;
        end else begin
          a_n     = bus.alu_result;
          disp_n  = bus.alu_result;
          state_n = SHOW;
        end
      end
    end else if (key_ok && bus.key_c) begin
      a_n     = '0;
      b_n     = '0;
      err_n   = 1'b0;
      disp_n  = '0;
      state_n = ENTER_A;
    end else if (key_ok) begin
      unique case (state)
        ENTER_A: begin
          if (bus.key_num) begin
            a_n    = acc_nxt;
            disp_n = acc_nxt;
          end else if (bus.key_op) begin
            op_n    = bus.key_operator;
            state_n = OP_WAIT;
          end
        end
        OP_WAIT: begin
          if (bus.key_num) begin
            b_n     = acc_nxt;
            disp_n  = acc_nxt;
            state_n = ENTER_B;
          end else if (bus.key_op) begin
            op_n = bus.key_operator;
          end
        end
        ENTER_B: begin
          if (bus.key_num) begin
            b_n    = acc_nxt;
            disp_n = acc_nxt;
          end else if (bus.key_equ) begin
            start_n = 1'b1;
            state_n = CALC;
          end
        end
        SHOW: begin
          if (bus.key_num) begin
            a_n     = acc_nxt;
            disp_n  = acc_nxt;
            state_n = ENTER_A;
          end else if (bus.key_op) begin
            op_n    = bus.key_operator;
            state_n = OP_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      start_q <= 1'b0;
      disp_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      start_q <= start_n;
      disp_q  <= disp_n;
      err_q   <= err_n;
      busy_q  <= (state_n == CALC);
    end
  end

  assign bus.alu_start  = start_q;
  assign bus.alu_op     = op_q;
  assign bus.operand_a  = a_q;
  assign bus.operand_b  = b_q;
  assign bus.disp_value = disp_q;
  assign bus.error      = err_q;
  assign bus.busy       = busy_q;
  assign state_dbg      = state;
endmodule
